// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin arbiter sharing one SPI transmitter among NREQ requesters
// Optional per-wait-state watchdog enabled by defining SPI_ARB_WDT_EN.
module spi_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int N          = 8,
    parameter int WDT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*N-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    spi_csn_mon,
    output logic                    tx_start,
    output logic [N-1:0]            tx_data,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    done,
    output logic                    timeout_err
);

    localparam int GW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || N < 1 || WDT_CYCLES < 1) begin : g_bad_cfg
        $error("spi_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t        state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] next_ptr;
    logic          sel_found;
    logic [GW-1:0] sel_idx;
    logic [GW:0]   cand;
    logic          settle;

    // Scan descending so the lowest offset from ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NREQ)) begin
                cand = cand - (GW+1)'(NREQ);
            end
            if (req_valid[cand[GW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        next_ptr = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end

`ifdef SPI_ARB_WDT_EN
    localparam int WCW = $clog2(WDT_CYCLES + 1);
    logic [WCW-1:0] wdt_cnt;
    logic           wdt_hit;
    assign wdt_hit = (wdt_cnt == WCW'(WDT_CYCLES - 1));
    // Hold off arbitration for the cycle that reports completion so a new start is two cycles later.
    assign settle  = done | timeout_err;
`else
    assign settle      = done;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            req_ready <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            done      <= 1'b0;
`ifdef SPI_ARB_WDT_EN
            timeout_err <= 1'b0;
            wdt_cnt     <= '0;
`endif
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            done      <= 1'b0;
`ifdef SPI_ARB_WDT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sel_found && !settle) begin
                        req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                        tx_start  <= 1'b1;
                        tx_data   <= req_data[sel_idx*N +: N];
                        grant_id  <= sel_idx;
                        busy      <= 1'b1;
                        state     <= WAIT_LOW;
`ifdef SPI_ARB_WDT_EN
                        wdt_cnt   <= '0;
`endif
                    end
                end
                WAIT_LOW: begin
                    if (!spi_csn_mon) begin
                        state <= WAIT_HIGH;
`ifdef SPI_ARB_WDT_EN
                        wdt_cnt <= '0;
                    end else if (wdt_hit) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end else begin
                        wdt_cnt <= wdt_cnt + 1'b1;
`endif
                    end
                end
                WAIT_HIGH: begin
                    if (spi_csn_mon) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                        state <= IDLE;
`ifdef SPI_ARB_WDT_EN
                    end else if (wdt_hit) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end else begin
                        wdt_cnt <= wdt_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - self-checking bench for spi_tx_arbiter with a CSn transmitter model
module tb_spi_tx_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 8;
    localparam int WDT  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        spi_csn_mon;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        done;
    logic        timeout_err;

    spi_tx_arbiter #(.NREQ(NREQ), .N(N), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .spi_csn_mon(spi_csn_mon), .tx_start(tx_start),
        .tx_data(tx_data), .busy(busy), .grant_id(grant_id), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         id;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] word;
        int         exp_id;
    } vec_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_done_cyc = -1;
    bit   gap_chk = 1'b0;
    int   done_cnt = 0;
    int   to_cnt = 0;
    int   grant_cnt[4] = '{default: 0};
    int   csn_low_len = 40;
    bit   csn_stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // what: 0 tx_start, 1 done, 2 csn low, 3 csn high
    task automatic wait_for(input int what, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((what == 0 && tx_start) || (what == 1 && done) ||
                (what == 2 && !spi_csn_mon) || (what == 3 && spi_csn_mon)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Transmitter model: CSn falls two cycles after tx_start and stays low csn_low_len cycles.
    initial begin
        spi_csn_mon = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start && !csn_stuck) begin
                repeat (2) @(negedge clk);
                spi_csn_mon = 1'b0;
                repeat (csn_low_len) @(negedge clk);
                spi_csn_mon = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL unexpected_tx_start: grant_id=%0d tx_data=%0h with empty scoreboard", grant_id, tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", 32'(tx_data), 32'(e.data));
                        check("grant_id", 32'(grant_id), e.id);
                        check("req_ready_onehot", 32'(req_ready), 32'(1) << e.id);
                    end
                    if (gap_chk && last_done_cyc >= 0) check("done_to_start_gap", cyc - last_done_cyc, 2);
                    grant_cnt[grant_id]++;
                end else if (req_ready != 4'b0) begin
                    check("req_ready_without_start", 32'(req_ready), 0);
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                if (timeout_err) to_cnt++;
            end
        end
    end

    initial begin : main
        vec_t vecs[5];
        bit   ok;
        int   n;
        int   dc;
        int   g1;

        vecs[0] = '{4'b0100, 8'hA5, 2};
        vecs[1] = '{4'b0001, 8'h3C, 0};
        vecs[2] = '{4'b1000, 8'hFF, 3};
        vecs[3] = '{4'b0010, 8'h00, 1};
        vecs[4] = '{4'b0010, 8'h5A, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start || busy) n++;
        end
        check("idle_activity", n, 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_tx_data", 32'(tx_data), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_done", 32'(done), 0);
        check("reset_timeout_err", 32'(timeout_err), 0);

        // Single-requester vectors, CSn low for 40 cycles each.
        for (int i = 0; i < 5; i++) begin
            req_data = 32'hC3C3_C3C3 ^ (32'h0101_0101 * i);
            req_data[vecs[i].exp_id*8 +: 8] = vecs[i].word;
            req_valid = vecs[i].valid;
            exp_q.push_back('{vecs[i].word, vecs[i].exp_id});
            @(negedge clk);
            check("grant_latency", 32'(tx_start), 1);
            check("busy_after_grant", 32'(busy), 1);
            if (!tx_start) wait_for(0, 20, ok);
            req_valid = 4'b0;
            wait_for(1, 200, ok);
            check("done_seen", 32'(ok), 1);
            check("busy_at_done", 32'(busy), 0);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 0);
            check("tx_data_hold", 32'(tx_data), 32'(vecs[i].word));
            repeat (3) @(negedge clk);
        end

        // Round-robin with all four requesters held valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        csn_low_len = 5;
        last_done_cyc = -1;
        gap_chk = 1'b1;
        req_data = 32'h1312_1110;
        for (int i = 0; i < 5; i++) exp_q.push_back('{8'h10 + 8'(i % 4), i % 4});
        req_valid = 4'hF;
        n = 0;
        while (n < 5) begin
            wait_for(0, 100, ok);
            if (!ok) break;
            n++;
        end
        req_valid = 4'b0;
        check("rr_grant_count", n, 5);
        wait_for(1, 100, ok);
        check("rr_final_done", 32'(ok), 1);
        gap_chk = 1'b0;
        repeat (5) @(negedge clk);
        check("rr_scoreboard_empty", exp_q.size(), 0);

        // Withdraw: requester 1 drops while requester 0 is served.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        csn_low_len = 10;
        g1 = grant_cnt[1];
        req_data = 32'h0000_B2A1;
        exp_q.push_back('{8'hA1, 0});
        req_valid = 4'b0011;
        wait_for(0, 10, ok);
        check("withdraw_grant0", 32'(ok), 1);
        req_valid = 4'b0;
        wait_for(1, 100, ok);
        repeat (20) @(negedge clk);
        check("withdrawn_not_granted", grant_cnt[1] - g1, 0);
        check("withdraw_idle", 32'(busy), 0);

        // Async reset while in WAIT_HIGH (ptr is 1 here, so a post-reset grant of 0 shows ptr cleared).
        csn_low_len = 30;
        req_data = 32'h0077_0000;
        exp_q.push_back('{8'h77, 2});
        req_valid = 4'b0100;
        wait_for(0, 10, ok);
        req_valid = 4'b0;
        wait_for(2, 20, ok);
        check("csn_went_low", 32'(ok), 1);
        repeat (3) @(negedge clk);
        dc = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_tx_data", 32'(tx_data), 0);
        check("async_rst_grant_id", 32'(grant_id), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_for(3, 60, ok);
        repeat (5) @(negedge clk);
        check("no_done_after_reset", done_cnt - dc, 0);
        req_data = 32'h0000_D2C1;
        exp_q.push_back('{8'hC1, 0});
        req_valid = 4'b0011;
        wait_for(0, 10, ok);
        check("post_reset_grant", 32'(ok), 1);
        req_valid = 4'b0;
        wait_for(1, 100, ok);
        repeat (3) @(negedge clk);

        // CSn stuck high after tx_start.
        csn_stuck = 1'b1;
        req_data = 32'h0000_00E0;
        exp_q.push_back('{8'hE0, 0});
        req_valid = 4'b0001;
        wait_for(0, 10, ok);
        req_valid = 4'b0;
`ifdef SPI_ARB_WDT_EN
        dc = done_cnt;
        n = 0;
        ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                n = i;
                ok = 1'b1;
                break;
            end
        end
        check("wdt_fired", 32'(ok), 1);
        check("wdt_latency", n, WDT);
        check("wdt_no_done", done_cnt - dc, 0);
        check("wdt_idle", 32'(busy), 0);
        @(negedge clk);
        check("wdt_one_cycle", 32'(timeout_err), 0);
        csn_stuck = 1'b0;
        req_data = 32'h0000_F1F0;
        exp_q.push_back('{8'hF1, 1});
        req_valid = 4'b0011;
        wait_for(0, 10, ok);
        check("wdt_next_grant", 32'(ok), 1);
        req_valid = 4'b0;
        wait_for(1, 100, ok);
`else
        repeat (40) @(negedge clk);
        check("stuck_still_busy", 32'(busy), 1);
        check("no_timeout_pulses", to_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
